// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared state encoding and constants for the fetch stage
//
// Purpose: FSM state type, default NOP/reset-PC constants and the fetch
// alignment check used by fetch_unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // RV32I without compressed instructions: targets must be word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding a single-cycle RV32I core
//
// Purpose: owns the architectural PC, fetches one instruction at a time over
// a req/gnt + rvalid handshake, presents it to the core for exactly one cycle
// (NOP otherwise) and captures the core's next_pc, halting with a sticky trap
// on a misaligned target.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req/addr     fetch request (held until gnt) and address (= PC)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata fetched word, valid one or more cycles after gnt
//   instruction, pc   to core: IR during EXEC else NOP; current PC
//   next_pc           from core, sampled in EXEC only
//   trap              sticky misaligned-fetch flag
//   retired           instructions issued to the core (wraps)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic        trap,
  output logic [31:0] retired
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         trap_q;
  logic [31:0]  retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      trap_q    <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_gnt) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            ir_q  <= imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The core executes IR this cycle even when its target traps.
          retired_q <= retired_q + 32'd1;
          if (is_aligned(next_pc)) begin
            pc_q  <= next_pc;
            state <= ST_FETCH;
          end else begin
            trap_q <= 1'b1;
            state  <= ST_HALT;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Only the EXEC cycle carries a real instruction, so the core's
  // register-file write never repeats.
  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instruction = (state == ST_EXEC) ? ir_q : NOP_INSTR;
  assign pc          = pc_q;
  assign trap        = trap_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] next_pc = 32'd0;
  logic        trap;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: where the next fetch goes and how many
  // instructions have been handed to the core.
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .next_pc(next_pc),
    .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  // Instruction memory contents; address 0 holds addi x1,x0,5.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_pc = RPC;
    m_retired = 32'd0;
  endtask

  // One full fetch: gnt after gd request cycles, rvalid rd cycles after gnt,
  // then the core answers npc in the execute cycle.
  task automatic fetch_one(input int gd, input int rd, input logic [31:0] npc, input bit spur);
    logic [31:0] w;
    w = word_at(m_pc);
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL fetch_req: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, m_pc);
      end
      n_checks++;
      if (instruction !== NOP || pc !== m_pc || retired !== m_retired) begin
        n_fail++;
        $display("FAIL fetch_idle: instr=%h pc=%h ret=%0d required %h %h %0d", instruction, pc, retired, NOP, m_pc, m_retired);
      end
      imem_gnt    = (i == gd);
      imem_rvalid = spur ? 1'b1 : 1'($urandom % 2);
      imem_rdata  = $urandom;
    end
    for (int j = 1; j <= rd; j++) begin
      @(negedge clk);
      imem_gnt = 1'($urandom % 2);
      n_checks++;
      if (imem_req !== 1'b0 || instruction !== NOP) begin
        n_fail++;
        $display("FAIL wait_state: req=%b instr=%h required req=0 instr=%h", imem_req, instruction, NOP);
      end
      imem_rvalid = (j == rd);
      imem_rdata  = (j == rd) ? w : $urandom;
    end
    @(negedge clk);
    imem_gnt    = 1'($urandom % 2);
    imem_rvalid = 1'($urandom % 2);
    imem_rdata  = $urandom;
    n_checks++;
    if (instruction !== w || pc !== m_pc || retired !== m_retired) begin
      n_fail++;
      $display("FAIL exec: instr=%h pc=%h ret=%0d required %h %h %0d", instruction, pc, retired, w, m_pc, m_retired);
    end
    next_pc = npc;
    m_retired = m_retired + 32'd1;
    if (npc[1:0] == 2'b00) m_pc = npc;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || instruction !== NOP ||
        trap !== 1'b0 || retired !== 32'd0 || pc !== RPC) begin
      n_fail++;
      $display("FAIL reset_state: req=%b addr=%h instr=%h trap=%b ret=%0d pc=%h", imem_req, imem_addr, instruction, trap, retired, pc);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    fetch_one(0, 1, 32'd4, 1'b0);
    @(negedge clk);
    n_checks++;
    if (pc !== 32'd4 || retired !== 32'd1 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_wait_after: pc=%h ret=%0d req=%b required 4 1 1", pc, retired, imem_req);
    end
  endtask

  task automatic test_delayed();
    do_reset();
    fetch_one(3, 4, m_pc + 32'd4, 1'b0);
    fetch_one(0, 2, m_pc + 32'd4, 1'b0);
  endtask

  task automatic test_branch();
    do_reset();
    fetch_one(0, 1, 32'h4, 1'b0);
    fetch_one(1, 1, 32'h8, 1'b0);
    fetch_one(0, 1, 32'h40, 1'b0);
    fetch_one(2, 1, 32'h44, 1'b0);
  endtask

  task automatic test_spurious();
    do_reset();
    fetch_one(3, 2, 32'h10, 1'b1);
    fetch_one(2, 1, 32'h14, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] npc;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      case ($urandom % 4)
        0, 1:    npc = m_pc + 32'd4;
        2:       npc = {22'd0, 8'($urandom), 2'b00};
        default: npc = m_pc + 32'd8;
      endcase
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), npc, 1'b0);
    end
  endtask

  task automatic test_trap();
    logic [31:0] held_pc;
    do_reset();
    fetch_one(0, 1, 32'h4, 1'b0);
    fetch_one(0, 1, 32'h8, 1'b0);
    held_pc = m_pc;
    fetch_one(1, 1, 32'h42, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (trap !== 1'b1 || imem_req !== 1'b0 || instruction !== NOP ||
          pc !== held_pc || retired !== m_retired) begin
        n_fail++;
        $display("FAIL halt: trap=%b req=%b instr=%h pc=%h ret=%0d required 1 0 %h %h %0d", trap, imem_req, instruction, pc, retired, NOP, held_pc, m_retired);
      end
      imem_gnt    = 1'($urandom % 2);
      imem_rvalid = 1'($urandom % 2);
      imem_rdata  = $urandom;
      next_pc     = $urandom;
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
      n_fail++;
      $display("FAIL trap_cleared: trap=%b req=%b addr=%h", trap, imem_req, imem_addr);
    end
  endtask

  task automatic test_rst_in_wait();
    do_reset();
    fetch_one(0, 1, 32'h4, 1'b0);
    fetch_one(0, 1, 32'h8, 1'b0);
    @(negedge clk);
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || instruction !== NOP ||
        retired !== 32'd0 || pc !== RPC) begin
      n_fail++;
      $display("FAIL rst_wait: req=%b addr=%h instr=%h ret=%0d pc=%h", imem_req, imem_addr, instruction, retired, pc);
    end
    @(negedge clk);
    n_checks++;
    if (instruction !== NOP || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_noexec: instr=%h req=%b required %h 1", instruction, imem_req, NOP);
    end
    m_pc = RPC;
    m_retired = 32'd0;
    fetch_one(0, 1, 32'h4, 1'b0);
  endtask

  initial begin
    m_pc = RPC;
    m_retired = 32'd0;
    test_reset();
    test_zero_wait();
    test_delayed();
    test_branch();
    test_spurious();
    test_random();
    test_trap();
    test_rst_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
